// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based hazard detection, forwarding select,
// freeze and multi-cycle branch flush for the in-order pipeline.
module hazard_ctrl #(
    parameter int REG_W     = 4,
    parameter int STAGES    = 2,
    parameter bit FWD_EN    = 1'b1,
    parameter int FLUSH_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic             id_src1_used,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src2_used,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             branch_taken,
    input  logic             stat_clr,
    output logic             freeze,
    output logic             flush,
    output logic [2:0]       fwd_sel1,
    output logic [2:0]       fwd_sel2,
    output logic [15:0]      stall_count
);

    logic [STAGES-1:0] r_sb_valid;
    logic [STAGES-1:0] r_sb_wb;
    logic [STAGES-1:0] r_sb_mr;
    logic [REG_W-1:0]  r_sb_dest [STAGES];
    logic [3:0]        r_flush_cnt;
    logic [15:0]       r_stall_cnt;

    logic [STAGES-1:0] w_m1;
    logic [STAGES-1:0] w_m2;
    logic              w_hazard;
    logic              w_issue;

    // Per-entry match of each ID source against in-flight destinations
    always_comb begin
        w_m1 = '0;
        w_m2 = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_m1[k] = r_sb_valid[k] & r_sb_wb[k] & id_src1_used
                      & (r_sb_dest[k] == id_src1);
            w_m2[k] = r_sb_valid[k] & r_sb_wb[k] & id_src2_used
                      & (r_sb_dest[k] == id_src2);
        end
    end

    // Hazard: load-use only when forwarding, any match otherwise
    always_comb begin
        w_hazard = 1'b0;
        if (FWD_EN) begin
            w_hazard = (w_m1[0] | w_m2[0]) & r_sb_mr[0];
        end else begin
            w_hazard = |(w_m1 | w_m2);
        end
    end

    assign flush       = branch_taken | (r_flush_cnt != 4'd0);
    assign freeze      = id_valid & w_hazard & ~flush;
    assign w_issue     = id_valid & ~freeze & ~flush;
    assign stall_count = r_stall_cnt;

    // Forward from the youngest matching entry; scan oldest first
    always_comb begin
        fwd_sel1 = 3'd0;
        fwd_sel2 = 3'd0;
        if (FWD_EN) begin
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (w_m1[k]) fwd_sel1 = 3'(k + 1);
                if (w_m2[k]) fwd_sel2 = 3'(k + 1);
            end
        end
    end

    // Scoreboard shift: new instruction or bubble enters entry 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sb_valid <= '0;
            r_sb_wb    <= '0;
            r_sb_mr    <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_sb_dest[k] <= '0;
            end
        end else begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                r_sb_valid[k] <= r_sb_valid[k-1];
                r_sb_wb[k]    <= r_sb_wb[k-1];
                r_sb_mr[k]    <= r_sb_mr[k-1];
                r_sb_dest[k]  <= r_sb_dest[k-1];
            end
            r_sb_valid[0] <= w_issue;
            r_sb_wb[0]    <= w_issue & id_wb_en;
            r_sb_mr[0]    <= w_issue & id_mem_r_en;
            r_sb_dest[0]  <= id_dest;
        end
    end

    // Flush counter: a taken branch (re)loads, otherwise count down
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush_cnt <= 4'd0;
        end else if (branch_taken) begin
            r_flush_cnt <= 4'(FLUSH_CYC - 1);
        end else if (r_flush_cnt != 4'd0) begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
        end
    end

    // Saturating freeze-cycle counter; clear beats increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 16'd0;
        end else if (stat_clr) begin
            r_stall_cnt <= 16'd0;
        end else if (freeze && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, stall-only, flush,
// reset and statistics behaviour across three parameterisations.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_src1;
    logic       id_src1_used;
    logic [3:0] id_src2;
    logic       id_src2_used;
    logic [3:0] id_dest;
    logic       id_wb_en;
    logic       id_mem_r_en;
    logic       branch_taken;
    logic       stat_clr;

    logic        f_freeze, f_flush;
    logic [2:0]  f_sel1, f_sel2;
    logic [15:0] f_cnt;
    logic        s_freeze, s_flush;
    logic [2:0]  s_sel1, s_sel2;
    logic [15:0] s_cnt;
    logic        t_freeze, t_flush;
    logic [2:0]  t_sel1, t_sel2;
    logic [15:0] t_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(4), .STAGES(2), .FWD_EN(1'b1), .FLUSH_CYC(3)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .branch_taken(branch_taken), .stat_clr(stat_clr),
        .freeze(f_freeze), .flush(f_flush),
        .fwd_sel1(f_sel1), .fwd_sel2(f_sel2), .stall_count(f_cnt)
    );

    hazard_ctrl #(.REG_W(4), .STAGES(2), .FWD_EN(1'b0), .FLUSH_CYC(1)) u_stl (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .branch_taken(branch_taken), .stat_clr(stat_clr),
        .freeze(s_freeze), .flush(s_flush),
        .fwd_sel1(s_sel1), .fwd_sel2(s_sel2), .stall_count(s_cnt)
    );

    hazard_ctrl #(.REG_W(4), .STAGES(7), .FWD_EN(1'b0), .FLUSH_CYC(1)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .branch_taken(branch_taken), .stat_clr(stat_clr),
        .freeze(t_freeze), .flush(t_flush),
        .fwd_sel1(t_sel1), .fwd_sel2(t_sel2), .stall_count(t_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [3:0] s1,
                         input logic u1, input logic [3:0] s2,
                         input logic u2, input logic [3:0] d,
                         input logic wb, input logic mr);
        id_valid     = v;
        id_src1      = s1;
        id_src1_used = u1;
        id_src2      = s2;
        id_src2_used = u2;
        id_dest      = d;
        id_wb_en     = wb;
        id_mem_r_en  = mr;
    endtask

    task automatic idle();
        issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            tick();
            idle();
        end
    endtask

    initial begin
        rst          = 1'b0;
        branch_taken = 1'b0;
        stat_clr     = 1'b0;
        idle();

        // reset held with random instruction inputs
        for (int i = 0; i < 4; i++) begin
            tick();
            issue(1'b1, 4'($urandom), 1'($urandom), 4'($urandom),
                  1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            stat_clr = 1'($urandom);
            #1;
            chk("rst_f_freeze", 32'(f_freeze), 32'd0);
            chk("rst_f_flush", 32'(f_flush), 32'd0);
            chk("rst_f_cnt", 32'(f_cnt), 32'd0);
            chk("rst_f_sel1", 32'(f_sel1), 32'd0);
            chk("rst_s_freeze", 32'(s_freeze), 32'd0);
            chk("rst_t_cnt", 32'(t_cnt), 32'd0);
        end
        tick();
        stat_clr = 1'b0;
        idle();
        rst = 1'b1;

        // independent stream: sources R0..R3, destinations R8..R11
        for (int i = 0; i < 20; i++) begin
            tick();
            issue(1'b1, 4'(i % 4), 1'b1, 4'((i + 1) % 4), 1'b1,
                  4'(8 + i % 4), 1'b1, 1'b0);
            #1;
            chk("indep_f_freeze", 32'(f_freeze), 32'd0);
            chk("indep_s_freeze", 32'(s_freeze), 32'd0);
            chk("indep_t_freeze", 32'(t_freeze), 32'd0);
        end
        drain(8);

        // ADD R1 then reader of R1: forward from EXE
        tick(); issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        tick(); issue(1'b1, 4'd1, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0);
        #1;
        chk("fwd1_freeze", 32'(f_freeze), 32'd0);
        chk("fwd1_sel1", 32'(f_sel1), 32'd1);
        chk("fwd1_sel2", 32'(f_sel2), 32'd0);
        drain(8);

        // one independent instruction between: forward from MEM
        tick(); issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        tick(); issue(1'b1, 4'd8, 1'b1, 4'd9, 1'b1, 4'd7, 1'b1, 1'b0);
        tick(); issue(1'b1, 4'd1, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0);
        #1;
        chk("fwd2_freeze", 32'(f_freeze), 32'd0);
        chk("fwd2_sel1", 32'(f_sel1), 32'd2);
        drain(8);

        // R1 written twice back-to-back: youngest wins on both sources
        tick(); issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        tick(); issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        tick(); issue(1'b1, 4'd1, 1'b1, 4'd1, 1'b1, 4'd6, 1'b1, 1'b0);
        #1;
        chk("young_sel1", 32'(f_sel1), 32'd1);
        chk("young_sel2", 32'(f_sel2), 32'd1);
        drain(8);

        // unused source does not match
        tick(); issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0);
        tick(); issue(1'b1, 4'd15, 1'b0, 4'd15, 1'b1, 4'd6, 1'b1, 1'b0);
        #1;
        chk("unused_sel1", 32'(f_sel1), 32'd0);
        chk("pc_sel2", 32'(f_sel2), 32'd1);
        drain(8);

        // load-use: LDR R2 then reader of R2 as src2
        tick(); issue(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
        tick(); issue(1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 4'd4, 1'b1, 1'b0);
        #1;
        chk("lu_freeze", 32'(f_freeze), 32'd1);
        chk("lu_cnt0", 32'(f_cnt), 32'd0);
        tick(); #1;
        chk("lu_freeze_after", 32'(f_freeze), 32'd0);
        chk("lu_sel2", 32'(f_sel2), 32'd2);
        chk("lu_sel1", 32'(f_sel1), 32'd0);
        chk("lu_cnt1", 32'(f_cnt), 32'd1);
        tick(); idle(); #1;
        chk("lu_cnt_hold", 32'(f_cnt), 32'd1);
        drain(8);
        tick(); stat_clr = 1'b1;
        tick(); stat_clr = 1'b0; #1;
        chk("clr_f_cnt", 32'(f_cnt), 32'd0);
        chk("clr_s_cnt", 32'(s_cnt), 32'd0);

        // stall-only: ADD R3 then reader stalls for 2 cycles
        tick(); issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        tick(); issue(1'b1, 4'd3, 1'b1, 4'd9, 1'b1, 4'd10, 1'b1, 1'b0);
        #1;
        chk("stl_freeze1", 32'(s_freeze), 32'd1);
        tick(); #1;
        chk("stl_freeze2", 32'(s_freeze), 32'd1);
        tick(); #1;
        chk("stl_freeze3", 32'(s_freeze), 32'd0);
        chk("stl_sel1", 32'(s_sel1), 32'd0);
        chk("stl_cnt", 32'(s_cnt), 32'd2);
        tick(); idle(); #1;
        chk("stl_cnt_hold", 32'(s_cnt), 32'd2);
        drain(8);

        // single branch: flush for 3 cycles
        for (int c = 0; c < 4; c++) begin
            tick();
            branch_taken = (c == 0);
            #1;
            chk("flush_single", 32'(f_flush), 32'(c < 3));
        end
        // second branch on the third cycle extends flush to 5 cycles
        for (int c = 0; c < 7; c++) begin
            tick();
            branch_taken = (c == 0) || (c == 2);
            #1;
            chk("flush_extend", 32'(f_flush), 32'(c < 5));
        end

        // flush overrides a simultaneous load-use hazard
        tick(); issue(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
        tick(); issue(1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 4'd4, 1'b1, 1'b0);
        branch_taken = 1'b1;
        #1;
        chk("ovr_freeze", 32'(f_freeze), 32'd0);
        chk("ovr_flush", 32'(f_flush), 32'd1);
        tick(); branch_taken = 1'b0; idle(); #1;
        chk("ovr_cnt", 32'(f_cnt), 32'd0);
        drain(8);

        // asynchronous reset in the middle of a flush
        tick(); branch_taken = 1'b1;
        tick(); branch_taken = 1'b0; #1;
        chk("mid_flush", 32'(f_flush), 32'd1);
        rst = 1'b0; #1;
        chk("mid_flush_rst", 32'(f_flush), 32'd0);
        tick(); rst = 1'b1;

        // reset clears scoreboard immediately, and after release
        tick(); issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        tick(); issue(1'b1, 4'd1, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0);
        #1;
        chk("pre_rst_sel1", 32'(f_sel1), 32'd1);
        rst = 1'b0; #1;
        chk("in_rst_sel1", 32'(f_sel1), 32'd0);
        rst = 1'b1; #1;
        chk("post_rst_sel1", 32'(f_sel1), 32'd0);
        drain(8);

        // saturation on the STAGES=7 stall-only instance
        tick(); stat_clr = 1'b1;
        tick(); stat_clr = 1'b0;
        issue(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        #1;
        chk("sat_start_freeze", 32'(t_freeze), 32'd0);
        chk("sat_start_cnt", 32'(t_cnt), 32'd0);
        repeat (8) @(posedge clk);
        #2;
        chk("sat_period", 32'(t_cnt), 32'd7);
        repeat (74896) @(posedge clk);
        #2;
        chk("sat_cnt", 32'(t_cnt), 32'hFFFF);
        chk("sat_phase", 32'(t_freeze), 32'd0);
        tick(); stat_clr = 1'b1; #1;
        chk("sat_clr_freeze", 32'(t_freeze), 32'd1);
        tick(); stat_clr = 1'b0; #1;
        chk("sat_clr_cnt", 32'(t_cnt), 32'd0);
        tick(); #1;
        chk("sat_recount", 32'(t_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
